// File: rtl/axis_pkt_pkg.sv
// rtl/axis_pkt_pkg.sv - shared defaults and debug state encoding for the AXI-Stream packetizer
package axis_pkt_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PKT_LEN    = 16;
    localparam int DEF_TIMEOUT    = 64;

    // Hold-register occupancy view; consumed by assertions only, not by the datapath.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        OPEN   = 2'd1,
        SEALED = 2'd2
    } pkt_state_e;

endpackage

// File: rtl/axis_packetizer.sv
// rtl/axis_packetizer.sv - frames an unframed word stream into PKT_LEN packets with idle-timeout sealing
module axis_packetizer
    import axis_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_LEN    = DEF_PKT_LEN,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int IDX_WIDTH  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
    input  logic                    s01_axis_aclk,
    input  logic                    s01_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic                    s01_axis_tvalid,
    output logic                    s01_axis_tready,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    output logic [15:0]             pkt_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
    logic                  h_last_q, h_last_d;
    logic                  hv_q, hv_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;

    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [STRB_W-1:0]     tstrb_q, tstrb_d;
    logic                  tlast_q, tlast_d;
    logic                  ov_q, ov_d;
    logic [15:0]           pkt_count_q, pkt_count_d;

    logic       o_free;
    logic       accept;
    logic       move;
    pkt_state_e state;

    always_comb begin
        o_free          = ~ov_q | m01_axis_tready;
        s01_axis_tready = ~hv_q | o_free;
        accept          = s01_axis_tvalid & s01_axis_tready;
        move            = hv_q & o_free & (accept | h_last_q);

        h_data_d    = h_data_q;
        h_last_d    = h_last_q;
        hv_d        = hv_q;
        idx_d       = idx_q;
        idle_cnt_d  = idle_cnt_q;
        tdata_d     = tdata_q;
        tstrb_d     = tstrb_q;
        tlast_d     = tlast_q;
        ov_d        = ov_q;
        pkt_count_d = pkt_count_q + 16'(ov_q & m01_axis_tready & tlast_q);

        // Accept has priority over sealing, so a word landing on the timeout cycle extends the packet.
        if (accept) begin
            h_data_d   = s01_axis_tdata;
            h_last_d   = (idx_q == LAST_IDX);
            hv_d       = 1'b1;
            idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            idle_cnt_d = '0;
        end else if (move) begin
            hv_d       = 1'b0;
            idle_cnt_d = '0;
        end else if (hv_q & ~h_last_q) begin
            if (idle_cnt_q != CNT_W'(TIMEOUT)) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                h_last_d = 1'b1;
                idx_d    = '0;
            end
        end

        if (move) begin
            ov_d    = 1'b1;
            tdata_d = h_data_q;
            tlast_d = h_last_q;
            tstrb_d = STRB_W'(1);
        end else if (m01_axis_tready & ov_q) begin
            ov_d = 1'b0;
        end

        if (!hv_q) begin
            state = EMPTY;
        end else if (h_last_q) begin
            state = SEALED;
        end else begin
            state = OPEN;
        end
    end

    always_ff @(posedge s01_axis_aclk) begin
        if (!s01_axis_aresetn) begin
            h_data_q    <= '0;
            h_last_q    <= 1'b0;
            hv_q        <= 1'b0;
            idx_q       <= '0;
            idle_cnt_q  <= '0;
            tdata_q     <= '0;
            tstrb_q     <= '0;
            tlast_q     <= 1'b0;
            ov_q        <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            h_data_q    <= h_data_d;
            h_last_q    <= h_last_d;
            hv_q        <= hv_d;
            idx_q       <= idx_d;
            idle_cnt_q  <= idle_cnt_d;
            tdata_q     <= tdata_d;
            tstrb_q     <= tstrb_d;
            tlast_q     <= tlast_d;
            ov_q        <= ov_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m01_axis_tdata  = tdata_q;
    assign m01_axis_tstrb  = tstrb_q;
    assign m01_axis_tvalid = ov_q;
    assign m01_axis_tlast  = tlast_q;
    assign pkt_count       = pkt_count_q;

    a_idx_range: assert property (@(posedge s01_axis_aclk) disable iff (!s01_axis_aresetn)
        idx_q <= LAST_IDX);

    a_empty_ready: assert property (@(posedge s01_axis_aclk) disable iff (!s01_axis_aresetn)
        (state == EMPTY) |-> s01_axis_tready);

    a_out_stable: assert property (@(posedge s01_axis_aclk) disable iff (!s01_axis_aresetn)
        (ov_q & ~m01_axis_tready) |=> (ov_q & (tdata_q == $past(tdata_q)) & (tlast_q == $past(tlast_q))));

endmodule

// File: tb/tb_axis_packetizer.sv
// tb/tb_axis_packetizer.sv - scoreboard bench for axis_packetizer in PKT_LEN=4 and PKT_LEN=1 configurations
module tb_axis_packetizer;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic [31:0] s4_tdata = '0;
    logic        s4_tvalid = 1'b0;
    logic        s4_tready;
    logic        m4_tready = 1'b1;
    logic [31:0] m4_tdata;
    logic [3:0]  m4_tstrb;
    logic        m4_tvalid;
    logic        m4_tlast;
    logic [15:0] pkt4;

    logic [31:0] s1_tdata = '0;
    logic        s1_tvalid = 1'b0;
    logic        s1_tready;
    logic        m1_tready = 1'b1;
    logic [31:0] m1_tdata;
    logic [3:0]  m1_tstrb;
    logic        m1_tvalid;
    logic        m1_tlast;
    logic [15:0] pkt1;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q4[$];
    exp_t q1[$];
    int   tb_idx = 0;
    logic saw_stall = 1'b0;
    logic stall_pend = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;

    always #5 clk = ~clk;

    axis_packetizer #(.DATA_WIDTH(32), .PKT_LEN(4), .TIMEOUT(8)) dut4 (
        .s01_axis_aclk    (clk),
        .s01_axis_aresetn (rstn),
        .s01_axis_tdata   (s4_tdata),
        .s01_axis_tvalid  (s4_tvalid),
        .s01_axis_tready  (s4_tready),
        .m01_axis_tready  (m4_tready),
        .m01_axis_tdata   (m4_tdata),
        .m01_axis_tstrb   (m4_tstrb),
        .m01_axis_tvalid  (m4_tvalid),
        .m01_axis_tlast   (m4_tlast),
        .pkt_count        (pkt4)
    );

    axis_packetizer #(.DATA_WIDTH(32), .PKT_LEN(1), .TIMEOUT(8)) dut1 (
        .s01_axis_aclk    (clk),
        .s01_axis_aresetn (rstn),
        .s01_axis_tdata   (s1_tdata),
        .s01_axis_tvalid  (s1_tvalid),
        .s01_axis_tready  (s1_tready),
        .m01_axis_tready  (m1_tready),
        .m01_axis_tdata   (m1_tdata),
        .m01_axis_tstrb   (m1_tstrb),
        .m01_axis_tvalid  (m1_tvalid),
        .m01_axis_tlast   (m1_tlast),
        .pkt_count        (pkt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (stall_pend) begin
                check("hold_valid", 32'(m4_tvalid), 32'd1);
                check("hold_data", m4_tdata, held_data);
                check("hold_last", 32'(m4_tlast), 32'(held_last));
            end
            stall_pend = m4_tvalid & ~m4_tready;
            held_data  = m4_tdata;
            held_last  = m4_tlast;
            if (!s4_tready) saw_stall = 1'b1;
            if (m4_tvalid && m4_tready) begin
                if (q4.size() == 0) begin
                    check("p4_extra_beat", m4_tdata, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = q4.pop_front();
                    check("p4_data", m4_tdata, e.data);
                    check("p4_last", 32'(m4_tlast), 32'(e.last));
                    check("p4_strb", 32'(m4_tstrb), 32'd1);
                end
            end
            if (m1_tvalid && m1_tready) begin
                if (q1.size() == 0) begin
                    check("p1_extra_beat", m1_tdata, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("p1_data", m1_tdata, e.data);
                    check("p1_last", 32'(m1_tlast), 32'(e.last));
                    check("p1_strb", 32'(m1_tstrb), 32'd1);
                end
            end
        end
    end

    task automatic send4(input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        s4_tdata  = d;
        s4_tvalid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = s4_tready;
            @(posedge clk);
            #1;
        end
        s4_tvalid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            q4.push_back('{data: d, last: (tb_idx == 3)});
            tb_idx = (tb_idx == 3) ? 0 : tb_idx + 1;
        end
    endtask

    // Source idle for n cycles after the last accept; TIMEOUT=8 or more seals an open packet.
    task automatic idle4(input int n);
        s4_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        if (n >= 8 && tb_idx != 0 && q4.size() != 0) begin
            q4[q4.size()-1].last = 1'b1;
            tb_idx = 0;
        end
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 100 && (q4.size() != 0 || q1.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        check(tag, 32'(q4.size() + q1.size()), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 32'(m4_tvalid), 32'd0);
        check({tag, "_tdata"}, m4_tdata, 32'd0);
        check({tag, "_tlast"}, 32'(m4_tlast), 32'd0);
        check({tag, "_tstrb"}, 32'(m4_tstrb), 32'd0);
        check({tag, "_pkt"}, 32'(pkt4), 32'd0);
        check({tag, "_sready"}, 32'(s4_tready), 32'd1);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        check("rst0_p1_sready", 32'(s1_tready), 32'd1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i <= 8; i++) send4(32'(i));
        drain("cont_drain");
        check("cont_pkt", 32'(pkt4), 32'd2);

        saw_stall = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send4(32'h21 + 32'(i));
            begin
                repeat (3) @(posedge clk);
                #1;
                m4_tready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                m4_tready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_sready_dropped", 32'(saw_stall), 32'd1);
        check("bp_pkt", 32'(pkt4), 32'd4);

        send4(32'hA);
        send4(32'hB);
        idle4(8);
        send4(32'hC);
        send4(32'hD);
        send4(32'hE);
        send4(32'hF);
        drain("to_drain");
        check("to_pkt", 32'(pkt4), 32'd6);

        send4(32'h10);
        idle4(7);
        send4(32'h11);
        send4(32'h12);
        send4(32'h13);
        drain("tob_drain");
        check("tob_pkt", 32'(pkt4), 32'd7);

        send4(32'h31);
        send4(32'h32);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        q4.delete();
        tb_idx = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_reset_outputs("rstm");
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) send4(32'h41 + 32'(i));
        drain("rstm_drain");
        check("rstm_pkt", 32'(pkt4), 32'd1);

        for (int i = 0; i < 3; i++) begin
            s1_tdata  = 32'h51 + 32'(i);
            s1_tvalid = 1'b1;
            @(negedge clk);
            check("p1_sready", 32'(s1_tready), 32'd1);
            q1.push_back('{data: s1_tdata, last: 1'b1});
            @(posedge clk);
            #1;
        end
        s1_tvalid = 1'b0;
        drain("p1_drain");
        check("p1_pkt", 32'(pkt1), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

- Single-clock AXI-Stream framing stage that sits directly upstream of the memory stage.
- Accepts unframed 32-bit words on a slave stream and re-emits them on a master stream with `tlast` asserted every `PKT_LEN` words.
- Closes a partial packet early when the source goes idle for `TIMEOUT` cycles.
- Uses a one-word hold register plus a registered output stage, so throughput is one word per cycle under backpressure with no loss.

## Interface

Parameters:
- `DATA_WIDTH`, 32, stream data width.
- `PKT_LEN`, 16, words per full packet (≥1). The downstream memory stage commits only beats with `tlast=1`, so the memory instance uses `PKT_LEN=1`.
- `TIMEOUT`, 64, idle cycles before a partial packet is sealed (≥1).
- `IDX_WIDTH`, `$clog2(PKT_LEN)` (minimum 1), width of the beat index.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `s01_axis_aclk` in 1: single clock for both stream sides.
  - `s01_axis_aresetn` in 1: synchronous, active-low reset.
- Slave stream:
  - `s01_axis_tdata` in `DATA_WIDTH`: input word.
  - `s01_axis_tvalid` in 1: input word valid.
  - `s01_axis_tready` out 1: combinational; ready to accept.
- Master stream:
  - `m01_axis_tready` in 1: downstream ready.
  - `m01_axis_tdata` out `DATA_WIDTH`: output word (registered).
  - `m01_axis_tstrb` out `DATA_WIDTH/8`: constant value 1 while `tvalid=1`.
  - `m01_axis_tvalid` out 1: output valid.
  - `m01_axis_tlast` out 1: last beat of packet.
- Status:
  - `pkt_count` out 16: count of completed packets, wraps at 2^16.

## Operation

- **Hold register H**: fields `h_data`, `h_last`, `hv`. **Output register O**: `m01_*` plus `ov` (`= m01_axis_tvalid`).
- **Derived signals**:
  - `o_free = ~ov | m01_axis_tready`
  - `s01_axis_tready = ~hv | o_free`
  - `accept = s01_axis_tvalid & s01_axis_tready`
- **Move H→O** when `hv & o_free & (accept | h_last)`. O loads `h_data`, `tlast = h_last`, `tstrb = 1`.
- **Accept**: H loads the input word. `h_last = (idx == PKT_LEN-1)`.
  - If the word is last, `idx` clears to 0; otherwise `idx` increments.
- **Idle counter** `idle_cnt`:
  - Increments while `hv & ~h_last & ~accept`.
  - Clears on `accept` or on a move.
  - When it reaches `TIMEOUT`, H is sealed: `h_last` is set to 1 and `idx` clears to 0.
  - The sealed word moves once `o_free`. Any later accept starts a new packet.
- **Output handshake**: O clears `ov` when `m01_axis_tready & ov` and no move occurs that cycle.
- **Packet counter**: `pkt_count` increments on each `m01_axis_tvalid & m01_axis_tready & m01_axis_tlast`.
- **State view**:
  - EMPTY (`~hv`)
  - OPEN (`hv`, `~h_last`)
  - SEALED (`hv`, `h_last`)
  - Transitions:
    - EMPTY→OPEN/SEALED on accept.
    - OPEN→SEALED on timeout.
    - OPEN→OPEN/SEALED on accept with move.
    - SEALED→EMPTY on move with no accept.
    - SEALED→OPEN/SEALED on move with accept.

## Timing

- **Reset values**: `hv=0`, `idx=0`, `idle_cnt=0`, `m01_axis_tvalid=0`, `tlast=0`, `tdata=0`, `tstrb=0`, `pkt_count=0`. `s01_axis_tready` reads 1 during and after reset (H is empty).
  - Reset mid-packet discards H, O and the partial packet. The next word is beat 0.
- **Latency**:
  - A word tagged last at accept edge N is valid on O after edge N+1 (if `o_free` at N+1).
  - A non-last word waits in H until the next accept or until sealing.
- **Simultaneous events**:
  - Accept and `idle_cnt` reaching `TIMEOUT` in the same cycle: accept wins, no seal.
  - Move and accept in the same cycle are allowed, giving full throughput.
- **Handshake rules**: `m01_axis_tdata`/`tlast` are stable while `tvalid & ~tready`. No combinational path from `m01_axis_tready` to `m01_*`; only `s01_axis_tready` is combinational.
- **Boundary cases**:
  - `PKT_LEN=1`: every beat has `tlast=1`.
  - `idx` never exceeds `PKT_LEN-1`.
  - `idle_cnt` saturates at `TIMEOUT` and is `$clog2(TIMEOUT+1)` bits wide.

## Structure

- Package `axis_pkt_pkg`: default `DATA_WIDTH`, `PKT_LEN`, `TIMEOUT`; state enum {EMPTY, OPEN, SEALED}, used for debug/assertions only.
- No sub-module: H, O and the counters stay flat in one module, roughly 150–200 lines.

## Test plan

- **Continuous stream**: `PKT_LEN=4`, 8 words 0x1..0x8 back-to-back, `m_tready=1` → 8 beats in order, `tlast` on 0x4 and 0x8, `pkt_count=2`.
- **Backpressure**: `m_tready=0` for 5 cycles mid-stream → `tvalid`/`tdata` held stable, `s_tready` drops once H and O are full, no word lost or duplicated.
- **Timeout seal**: `TIMEOUT=8`, `PKT_LEN=4`, words 0xA, 0xB, then idle → 0xA emitted untagged, 0xB emitted with `tlast` 8 idle cycles later. A following 0xC, 0xD, 0xE, 0xF gives `tlast` on 0xF.
- **Timeout boundary**: `TIMEOUT=8`, next word arrives on the 8th idle cycle → no seal, packet continues.
- **Reset mid-packet**: reset after 2 of 4 words → all outputs at reset values. Next 4 words form one packet with `tlast` on the 4th.
- **`PKT_LEN=1` into memory-stage configuration**: 3 words → 3 beats, each with `tlast=1`, `tstrb=1`, `pkt_count=3`.
